// File: rtl/edge_frame_writer_if.sv
// edge_frame_writer_if: frame-buffer write port (valid/ready handshake, address, data)
interface edge_frame_writer_if #(
  parameter int ADDR_W = 19
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        data;
  modport master (output valid, addr, data, input ready);
  modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/edge_frame_writer.sv
// edge_frame_writer: realigns Sobel edge pixels to window-centre addresses, zeroes borders, buffers and drains writes; EDGE_WR_THRESH_EN enables binarisation
module edge_frame_writer #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 8,
  parameter int THRESH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start_i,
  input  logic [3:0]                 pix_data_i,
  input  logic                       pix_valid_i,
  edge_frame_writer_if.master        wr,
  output logic                       frame_done_o,
  output logic                       busy_o,
  output logic                       overflow_o,
  output logic                       stray_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] OFF     = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(IMG_H - 1);
  localparam logic [PW:0]       DEPTH   = (PW + 1)'(FIFO_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [PW:0]       wp_q, wp_d, rp_q, rp_d;
  logic              done_q, done_d, ovf_q, ovf_d, stray_q, stray_d;
  logic [ADDR_W-1:0] fa [FIFO_DEPTH];
  logic [3:0]        fd [FIFO_DEPTH];
  logic              empty, full, pop, pix_run, primed, adv, push, border;
  logic [3:0]        shaped, push_data;

  assign empty   = wp_q == rp_q;
  assign full    = (wp_q - rp_q) == DEPTH;
  assign pop     = !empty && wr.ready;
  assign pix_run = state_q == RUN && pix_valid_i;
  assign primed  = k_q >= OFF;
  // an address is consumed by every primed RUN pixel (even if dropped) and by each non-stalled flush slot
  assign adv     = (pix_run && primed) || (state_q == FLUSH && !full);
  assign push    = adv && !full;
  assign border  = row_q == '0 || row_q == ROW_MAX || col_q == '0 || col_q == COL_MAX;
`ifdef EDGE_WR_THRESH_EN
  assign shaped  = pix_data_i >= 4'(THRESH) ? 4'hF : 4'h0;
`else
  assign shaped  = pix_data_i;
`endif
  assign push_data = (border || state_q != RUN) ? 4'h0 : shaped;

  assign wr.valid     = !empty;
  assign wr.addr      = empty ? '0 : fa[rp_q[PW-1:0]];
  assign wr.data      = empty ? 4'h0 : fd[rp_q[PW-1:0]];
  assign busy_o       = state_q != IDLE;
  assign frame_done_o = done_q;
  assign overflow_o   = ovf_q;
  assign stray_o      = stray_q;

  // frame sequencing and centre-address tracking
  always_comb begin
    state_d = state_q;
    k_d     = pix_run ? k_q + ADDR_W'(1) : k_q;
    a_d     = adv ? a_q + ADDR_W'(1) : a_q;
    col_d   = adv ? (col_q == COL_MAX ? '0 : col_q + ADDR_W'(1)) : col_q;
    row_d   = adv && col_q == COL_MAX ? row_q + ADDR_W'(1) : row_q;
    if (state_q == IDLE && frame_start_i) begin
      state_d = RUN;
      k_d     = '0;
      a_d     = '0;
      row_d   = '0;
      col_d   = '0;
    end
    if (pix_run && k_q == LAST) state_d = FLUSH;
    if (state_q == FLUSH && !full && a_q == LAST) state_d = DRAIN;
    if (state_q == DRAIN && empty) state_d = IDLE;
  end

  // FIFO pointers and status flags
  always_comb begin
    wp_d    = wp_q + (PW + 1)'(push);
    rp_d    = rp_q + (PW + 1)'(pop);
    done_d  = state_q == DRAIN && empty;
    ovf_d   = ovf_q || (pix_run && primed && full);
    stray_d = stray_q || (pix_valid_i && state_q != RUN);
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      stray_q <= stray_d;
    end
  end

  // FIFO storage; contents are only visible while the pointers say non-empty
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wp_q[PW-1:0]] <= a_q;
      fd[wp_q[PW-1:0]] <= push_data;
    end
  end
endmodule

// File: tb/tb_edge_frame_writer.sv
// tb_edge_frame_writer: directed bench for edge_frame_writer on a 4x3 frame, FIFO depth 4
module tb_edge_frame_writer;
  localparam int W = 4, H = 3, N = 12, OFF = 5;
  logic clk = 1'b0;
  logic rst, frame_start, pix_valid;
  logic [3:0] pix_data;
  logic frame_done, busy, overflow, stray;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [3:0] px [N];
  int got_a [$];
  logic [3:0] got_d [$];
  int ovf_list [9] = '{0, 1, 2, 3, 7, 8, 9, 10, 11};

  edge_frame_writer_if #(.ADDR_W(4)) wr ();
  edge_frame_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(4), .FIFO_DEPTH(4), .THRESH(4)) dut (
    .clk(clk), .rst(rst), .frame_start_i(frame_start), .pix_data_i(pix_data),
    .pix_valid_i(pix_valid), .wr(wr), .frame_done_o(frame_done), .busy_o(busy),
    .overflow_o(overflow), .stray_o(stray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic logic [3:0] exp_d(input int a);
    logic [3:0] d;
    if (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1) return 4'h0;
    d = px[a + OFF];
`ifdef EDGE_WR_THRESH_EN
    return d >= 4'd4 ? 4'hF : 4'h0;
`else
    return d;
`endif
  endfunction

  always @(negedge clk) begin
    if (wr.valid && wr.ready) begin
      got_a.push_back(int'(wr.addr));
      got_d.push_back(wr.data);
    end
    if (frame_done) begin
      done_cnt++;
      check("busy_at_done", busy, 0);
    end
  end

  task automatic start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic send_px(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      pix_valid = 1'b1;
      pix_data  = px[k];
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0 = done_cnt;
    int t = 0;
    while (done_cnt == n0 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    check(tag, done_cnt - n0, 1);
    @(posedge clk); #1;
    check({tag, "_one_cycle"}, frame_done, 0);
  endtask

  task automatic check_writes(input int base, input string tag);
    for (int i = 0; i < N && base + i < got_a.size(); i++) begin
      check({tag, "_addr"}, got_a[base + i], i);
      check({tag, "_data"}, got_d[base + i], exp_d(i));
    end
  endtask

  task automatic clear();
    got_a.delete();
    got_d.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int t, nd;
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 4'h0; wr.ready = 1'b1;
    for (int k = 0; k < N; k++) px[k] = 4'(k + 1);
    #1;
    check("rst_valid", wr.valid, 0);
    check("rst_addr", wr.addr, 0);
    check("rst_data", wr.data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_stray", stray, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // plain frame, ready always high
    clear();
    start();
    check("busy_run", busy, 1);
    send_px(0, N);
    wait_done("f1_done");
    check("f1_count", got_a.size(), N);
    check_writes(0, "f1");
    if (got_d.size() == N) begin
`ifdef EDGE_WR_THRESH_EN
      check("f1_a5", got_d[5], 4'hF);
      check("f1_a6", got_d[6], 4'hF);
`else
      check("f1_a5", got_d[5], 11);
      check("f1_a6", got_d[6], 12);
`endif
    end
    check("f1_busy", busy, 0);

    // backpressure: FIFO fills, later pixels overflow
    clear();
    wr.ready = 1'b0;
    nd = done_cnt;
    start();
    send_px(0, 9);
    check("ovf_at_full", overflow, 0);
    send_px(9, N);
    check("ovf_set", overflow, 1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_valid", wr.valid, 1);
    check("hold_addr", wr.addr, 0);
    check("hold_data", wr.data, 0);
    check("hold_busy", busy, 1);
    check("hold_no_done", done_cnt, nd);
    check("hold_no_writes", got_a.size(), 0);
    wr.ready = 1'b1;
    wait_done("ovf_done");
    check("ovf_count", got_a.size(), 9);
    for (int i = 0; i < 9 && i < got_a.size(); i++) begin
      check("ovf_addr", got_a[i], ovf_list[i]);
      check("ovf_data", got_d[i], 0);
    end
    check("ovf_sticky", overflow, 1);

    // stray pixels in IDLE and DRAIN
    pulse_rst();
    check("clr_ovf", overflow, 0);
    pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    check("stray_idle", stray, 1);
    check("stray_idle_nowr", wr.valid, 0);
    check("stray_idle_busy", busy, 0);
    pulse_rst();
    check("clr_stray", stray, 0);
    clear();
    start();
    send_px(0, N);
    check("stray_run", stray, 0);
    t = 0;
    while (got_a.size() < N && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    check("drain_reach", got_a.size(), N);
    pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    wait_done("stray_done");
    check("stray_drain", stray, 1);
    check("stray_count", got_a.size(), N);
    check_writes(0, "stray");

    // reset in the middle of a frame
    clear();
    wr.ready = 1'b0;
    start();
    send_px(0, 7);
    check("mid_valid", wr.valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", wr.valid, 0);
    check("mid_rst_addr", wr.addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_stray", stray, 0);
    check("mid_rst_done", frame_done, 0);
    @(posedge clk); #1 rst = 1'b0;
    wr.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_writes", got_a.size(), 0);
    start();
    send_px(0, N);
    wait_done("mid_done");
    check("mid_count", got_a.size(), N);
    check_writes(0, "mid");

    // centre pixels straddling the threshold
    clear();
    px[10] = 4'd3;
    px[11] = 4'd9;
    start();
    send_px(0, N);
    wait_done("thr_done");
    check("thr_count", got_a.size(), N);
    if (got_d.size() == N) begin
`ifdef EDGE_WR_THRESH_EN
      check("thr_lo", got_d[5], 4'h0);
      check("thr_hi", got_d[6], 4'hF);
`else
      check("thr_lo", got_d[5], 3);
      check("thr_hi", got_d[6], 9);
`endif
    end
    check_writes(0, "thr");

    // back-to-back frames
    for (int k = 0; k < N; k++) px[k] = 4'(k + 1);
    clear();
    start();
    send_px(0, N);
    wait_done("b2b_done1");
    start();
    send_px(0, N);
    wait_done("b2b_done2");
    check("b2b_count", got_a.size(), 2 * N);
    check_writes(0, "b2b1");
    check_writes(N, "b2b2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/edge_frame_writer.md
Name: edge_frame_writer

Overview:
- Sink for the Sobel filter's 4-bit edge pixel stream, which arrives as a data bus plus a per-pixel valid strobe.
- Realigns each pixel to the frame address of its 3x3 window centre and forces border pixels to 0.
- Buffers the resulting (address, data) writes in a small FIFO and drains them to the frame-buffer write port under a valid/ready handshake.
- Pulses frame_done once every address of the frame has been written.

Parameters:
- IMG_W, 640, frame width in pixels (>=3)
- IMG_H, 480, frame height in pixels (>=3)
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- FIFO_DEPTH, 8, write FIFO entries; power of two, >=2
- THRESH, 4, binarisation threshold, used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  single-cycle pulse that arms the writer for one frame
- pix_data  in  4  edge pixel from the filter
- pix_valid  in  1  pix_data valid this cycle; no backpressure toward the filter
- mem_wr_valid  out  1  FIFO head holds a pending write
- mem_wr_ready  in  1  frame buffer accepts the head write
- mem_wr_addr  out  ADDR_W  head write address
- mem_wr_data  out  4  head write data
- frame_done  out  1  one-cycle pulse, frame fully written
- busy  out  1  state != IDLE
- overflow  out  1  sticky: pixel lost because the FIFO was full
- stray  out  1  sticky: pix_valid seen outside RUN

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pixel counter k=0, flush counter=0.
  - FIFO emptied: mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0.
  - frame_done=0, busy=0, overflow=0, stray=0.
  - Reset mid-frame abandons the frame; no further writes are issued.
- Definitions: N=IMG_W*IMG_H; OFF=IMG_W+1.
- IDLE:
  - frame_start -> RUN, k<=0.
  - pix_valid in IDLE sets stray; the pixel is discarded.
- RUN: on each pix_valid, k increments.
  - If k<OFF, the pixel is discarded (window not yet primed).
  - Otherwise a=k-OFF, row=a/IMG_W, col=a%IMG_W. Track row/col with counters, no divider.
  - Push (a, d): d=0 if row==0, row==IMG_H-1, col==0 or col==IMG_W-1; otherwise d=pix_data.
  - When the pixel with k==N-1 is accepted -> FLUSH.
  - frame_start while busy is ignored.
- FLUSH:
  - Pushes OFF writes with data 0 to addresses N-OFF..N-1, one per cycle while the FIFO is not full. All of these are border addresses.
  - After the last push -> DRAIN.
  - pix_valid in FLUSH or DRAIN sets stray and is discarded.
- DRAIN:
  - When the FIFO is empty, frame_done=1 for exactly one cycle and state -> IDLE.
  - A frame_start in that same cycle is ignored.
- Totals: exactly N writes per frame, addresses 0..N-1, each once, in ascending order.
- FIFO:
  - mem_wr_valid = not empty; mem_wr_addr and mem_wr_data come from the head (registered storage).
  - Pop when mem_wr_valid & mem_wr_ready.
  - Full is evaluated before the same-cycle pop. A RUN push while full is dropped and sets overflow; k and row/col still advance, so the dropped address is never written.
  - FLUSH stalls rather than drops, so FLUSH never sets overflow.
  - Head entries are stable while mem_wr_valid=1 and mem_wr_ready=0.
- Latency: a pushed entry appears on mem_wr_* one cycle after the push edge if the FIFO was empty.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: EDGE_WR_THRESH_EN.
- Defined: non-border data is binarised to 4'hF if pix_data>=THRESH, else 4'h0. Border data stays 0.
- Undefined: pix_data passes unchanged and THRESH is unused.

Test Plan:
- IMG_W=4, IMG_H=3, FIFO_DEPTH=8, mem_wr_ready=1; frame_start, then 12 pixels with pix_data=k+1 -> 12 writes to addresses 0..11.
  - Address 5 = data 11 (k=10), address 6 = data 12 (k=11); all other addresses = 0.
  - frame_done pulses once after the last write; busy falls the same cycle.
- Same frame with mem_wr_ready=0 throughout, FIFO_DEPTH=4 -> 4 entries are held stable.
  - Addresses 0..1 come from k=5,6, so the fourth entry comes from k=8; k=9..11 set overflow.
  - No frame_done while the FIFO is non-empty. Raising mem_wr_ready drains the FIFO and then the flush writes.
- pix_valid pulses before frame_start and during DRAIN -> stray=1; write count and addresses unchanged.
- Reset asserted after the 7th pixel with the FIFO non-empty -> mem_wr_valid=0 immediately, all flags 0, state IDLE.
  - A following clean frame produces 12 correct writes.
- EDGE_WR_THRESH_EN defined, THRESH=4, centre pixels 3 and 9 -> written data 0x0 and 0xF; borders 0.
- Back-to-back frames with frame_start issued the cycle after frame_done -> second frame starts at address 0; 24 writes total.
